// File: rtl/i2s_rx_packer_if.sv
// i2s_rx_packer_if: valid/ready stream carrying packed {left,right} frames to the consumer.
interface i2s_rx_packer_if #(parameter int W = 32);
   logic [W-1:0] sample_data;
   logic         sample_valid;
   logic         sample_ready;
   modport master (output sample_data, sample_valid, input sample_ready);
   modport slave  (input sample_data, sample_valid, output sample_ready);
endinterface

// File: rtl/i2s_rx_packer.sv
// i2s_rx_packer: I2S capture into a {left,right} frame FIFO on mon_clk.
// Define I2S_RX_LJ_EN for left-justified framing (MSB on the lrck-change bit).
module i2s_rx_packer #(
   parameter int WIDTH      = 16,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic                  mon_clk,
   input  logic                  reset_n,
   input  logic                  enable,
   input  logic                  bclk,
   input  logic                  lrck,
   input  logic                  sdata,
   i2s_rx_packer_if.master       smp,
   output logic                  overflow,
   input  logic                  clear_ovf,
   output logic [DEPTH_LOG2:0]   fifo_level
);
   localparam int DEPTH = 2**DEPTH_LOG2;
   localparam int CW    = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE, WAIT_L, LEFT, RIGHT} state_t;
   state_t                state, state_nxt;
   logic [2:0]            bclk_q;
   logic [1:0]            lr_q, sd_q;
   logic                  lr_prev, tick, chg, lr_s, bit_s, push, pop, full, wr;
   logic [WIDTH-1:0]      sr, left_w, ins, fin, sr0;
   logic [CW-1:0]         count, c0, sh;
   logic [2*WIDTH-1:0]    mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wp, rp;

   assign tick  = bclk_q[1] & ~bclk_q[2];
   assign lr_s  = lr_q[1];
   assign bit_s = sd_q[1];
   assign chg   = tick & (lr_s != lr_prev);
   assign sh    = CW'(WIDTH - 1) - count;
   // Bits land MSB-first at their final position, so short words come out left-aligned.
   assign ins   = (count < CW'(WIDTH)) ? sr | ({{(WIDTH-1){1'b0}}, bit_s} << sh) : sr;
`ifdef I2S_RX_LJ_EN
   assign fin   = sr;
   assign sr0   = {bit_s, {(WIDTH-1){1'b0}}};
   assign c0    = CW'(1);
`else
   assign fin   = ins;
   assign sr0   = '0;
   assign c0    = '0;
`endif
   assign push  = enable & chg & (state == RIGHT);
   assign pop   = smp.sample_valid & smp.sample_ready;
   assign full  = fifo_level == (DEPTH_LOG2+1)'(DEPTH);
   assign wr    = push & (~full | pop);
   assign smp.sample_valid = fifo_level != '0;
   assign smp.sample_data  = mem[rp];

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = WAIT_L;
         WAIT_L:  state_nxt = (chg & ~lr_s) ? LEFT : WAIT_L;
         LEFT:    state_nxt = chg ? RIGHT : LEFT;
         RIGHT:   state_nxt = chg ? LEFT : RIGHT;
         default: state_nxt = IDLE;
      endcase
      if (!enable) state_nxt = IDLE;
   end

   always_ff @(posedge mon_clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= IDLE;
         bclk_q  <= '0;
         lr_q    <= '0;
         sd_q    <= '0;
         lr_prev <= 1'b0;
         sr      <= '0;
         count   <= '0;
         left_w  <= '0;
      end else begin
         state  <= state_nxt;
         bclk_q <= {bclk_q[1:0], bclk};
         lr_q   <= {lr_q[0], lrck};
         sd_q   <= {sd_q[0], sdata};
         if (tick) lr_prev <= lr_s;
         if (state == WAIT_L && chg && !lr_s) begin
            sr    <= sr0;
            count <= c0;
         end else if ((state == LEFT || state == RIGHT) && tick) begin
            if (chg) begin
               sr    <= sr0;
               count <= c0;
               if (state == LEFT) left_w <= fin;
            end else begin
               sr    <= ins;
               count <= count + CW'(count < CW'(WIDTH));
            end
         end
      end
   end

   always_ff @(posedge mon_clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wp         <= '0;
         rp         <= '0;
         fifo_level <= '0;
         overflow   <= 1'b0;
      end else begin
         if (wr) begin
            mem[wp] <= {left_w, fin};
            wp      <= wp + 1'b1;
         end
         if (pop) rp <= rp + 1'b1;
         fifo_level <= fifo_level + (DEPTH_LOG2+1)'(wr) - (DEPTH_LOG2+1)'(pop);
         overflow   <= clear_ovf ? 1'b0 : overflow | (push & full & ~pop);
      end
   end
endmodule
